// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS main controller and its datapath.
// The controller (master) receives the opcode and drives every datapath strobe.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic             pcwrite;
    logic             pcwritecond;
    logic             brtype;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regdst;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsource;
    logic             aluop1;
    logic             aluop2;
    logic             done;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  op,
        output pcwrite, pcwritecond, brtype, iord, memread, memwrite, irwrite,
        output memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
        output aluop1, aluop2, done, illegal, state, instr_count
    );

    modport slave (
        output op,
        input  pcwrite, pcwritecond, brtype, iord, memread, memwrite, irwrite,
        input  memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
        input  aluop1, aluop2, done, illegal, state, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Main Moore control FSM for the multicycle MIPS datapath: sequences each
// instruction from its opcode, counts retired instructions, flags illegal opcodes.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BLT  = 6'd6;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SUBI = 6'd9;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        ADDI_EX  = 4'd6,
        SUBI_EX  = 4'd7,
        RTYPE_EX = 4'd8,
        RTYPE_WB = 4'd9,
        IMM_WB   = 4'd10,
        BEQ      = 4'd11,
        BLT      = 4'd12,
        JUMP     = 4'd13
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;

    state_t     dec_state;
    logic       pcwrite_d, pcwritecond_d, brtype_d, iord_d, memread_d, memwrite_d;
    logic       irwrite_d, memtoreg_d, regdst_d, regwrite_d, alusrca_d;
    logic       done_d, illegal_d;
    logic [1:0] alusrcb_d, pcsource_d, aluop_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            count_reg <= '0;
        end else begin
            if (done_d) begin
                count_reg <= count_reg + CNT_W'(1);
            end
            case (state_reg)
                FETCH:  state_reg <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_R:          state_reg <= RTYPE_EX;
                        OP_J:          state_reg <= JUMP;
                        OP_BEQ:        state_reg <= BEQ;
                        OP_BLT:        state_reg <= BLT;
                        OP_ADDI:       state_reg <= ADDI_EX;
                        OP_SUBI:       state_reg <= SUBI_EX;
                        OP_LW, OP_SW:  state_reg <= MEMADR;
                        default:       state_reg <= FETCH;
                    endcase
                end
                MEMADR:            state_reg <= (bus.op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:             state_reg <= MEMWB;
                ADDI_EX, SUBI_EX:  state_reg <= IMM_WB;
                RTYPE_EX:          state_reg <= RTYPE_WB;
                default:           state_reg <= FETCH;
            endcase
        end
    end

    // Under reset the decoder sees FETCH so non-strobe outputs show fetch values.
    always_comb begin
        dec_state     = reset ? FETCH : state_reg;
        pcwrite_d     = 1'b0;
        pcwritecond_d = 1'b0;
        brtype_d      = 1'b0;
        iord_d        = 1'b0;
        memread_d     = 1'b0;
        memwrite_d    = 1'b0;
        irwrite_d     = 1'b0;
        memtoreg_d    = 1'b0;
        regdst_d      = 1'b0;
        regwrite_d    = 1'b0;
        alusrca_d     = 1'b0;
        alusrcb_d     = 2'b00;
        pcsource_d    = 2'b00;
        aluop_d       = 2'b00;
        done_d        = 1'b0;
        illegal_d     = 1'b0;
        case (dec_state)
            FETCH: begin
                memread_d = 1'b1;
                irwrite_d = 1'b1;
                pcwrite_d = 1'b1;
                alusrcb_d = 2'b01;
            end
            DECODE: begin
                alusrcb_d = 2'b11;
                illegal_d = !(bus.op inside {OP_R, OP_J, OP_BEQ, OP_BLT,
                                             OP_ADDI, OP_SUBI, OP_LW, OP_SW});
            end
            MEMADR, ADDI_EX: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
            end
            SUBI_EX: begin
                alusrca_d = 1'b1;
                alusrcb_d = 2'b10;
                aluop_d   = 2'b01;
            end
            MEMRD: begin
                memread_d = 1'b1;
                iord_d    = 1'b1;
            end
            MEMWB: begin
                regwrite_d = 1'b1;
                memtoreg_d = 1'b1;
                done_d     = 1'b1;
            end
            MEMWR: begin
                memwrite_d = 1'b1;
                iord_d     = 1'b1;
                done_d     = 1'b1;
            end
            RTYPE_EX: begin
                alusrca_d = 1'b1;
                aluop_d   = 2'b10;
            end
            RTYPE_WB: begin
                regwrite_d = 1'b1;
                regdst_d   = 1'b1;
                done_d     = 1'b1;
            end
            IMM_WB: begin
                regwrite_d = 1'b1;
                done_d     = 1'b1;
            end
            BEQ, BLT: begin
                alusrca_d     = 1'b1;
                aluop_d       = 2'b01;
                pcwritecond_d = 1'b1;
                pcsource_d    = 2'b01;
                brtype_d      = (dec_state == BLT);
                done_d        = 1'b1;
            end
            JUMP: begin
                pcwrite_d  = 1'b1;
                pcsource_d = 2'b10;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pcwrite     = pcwrite_d & ~reset;
    assign bus.pcwritecond = pcwritecond_d & ~reset;
    assign bus.memwrite    = memwrite_d & ~reset;
    assign bus.regwrite    = regwrite_d & ~reset;
    assign bus.irwrite     = irwrite_d & ~reset;
    assign bus.done        = done_d & ~reset;
    assign bus.illegal     = illegal_d & ~reset;
    assign bus.brtype      = brtype_d;
    assign bus.iord        = iord_d;
    assign bus.memread     = memread_d;
    assign bus.memtoreg    = memtoreg_d;
    assign bus.regdst      = regdst_d;
    assign bus.alusrca     = alusrca_d;
    assign bus.alusrcb     = alusrcb_d;
    assign bus.pcsource    = pcsource_d;
    assign bus.aluop1      = aluop_d[1];
    assign bus.aluop2      = aluop_d[0];
    assign bus.state       = state_reg;
    assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a driver pushes per-cycle control
// words and per-instruction transactions; a negedge monitor pops and compares.
module tb_multicycle_control;
    // Narrow counter so the all-ones -> 0 wrap is reached within a short run.
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();
    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       brtype;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic       aluop1;
        logic       aluop2;
        logic       done;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t             c;
        logic [3:0]       st;
        logic [CNT_W-1:0] cnt;
        bit               chk;
    } step_t;

    typedef struct {
        bit         ill;
        int         lat;
        logic [5:0] op;
    } txn_t;

    step_t            exp_q[$];
    txn_t             txn_q[$];
    int               checks = 0;
    int               errors = 0;
    int               steps_n = 0;
    int               cyc = 0;
    bit               mon_en = 1'b0;
    logic [CNT_W-1:0] model_cnt = '0;

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd9, 6'd35, 6'd43};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_step(input ctl_t c, input int st, input bit d);
        step_t s;
        s.c   = c;
        s.st  = 4'(st);
        s.cnt = model_cnt;
        s.chk = 1'b1;
        exp_q.push_back(s);
        steps_n++;
        if (d) model_cnt++;
    endtask

    task automatic push_reset_step();
        step_t s;
        s.c         = '0;
        s.c.memread = 1'b1;
        s.c.alusrcb = 2'b01;
        s.st        = '0;
        s.cnt       = '0;
        s.chk       = 1'b0;
        exp_q.push_back(s);
    endtask

    task automatic push_fetch_decode(input logic [5:0] o);
        ctl_t c;
        c = '0; c.memread = 1; c.irwrite = 1; c.pcwrite = 1; c.alusrcb = 2'b01;
        push_step(c, 0, 0);
        c = '0; c.alusrcb = 2'b11; c.illegal = !is_legal(o);
        push_step(c, 1, 0);
    endtask

    // Reference: each instruction class expands to its list of control words.
    task automatic issue(input logic [5:0] o);
        ctl_t c;
        txn_t t;
        steps_n = 0;
        bus.op  = o;
        push_fetch_decode(o);
        case (o)
            6'd0: begin
                c = '0; c.alusrca = 1; c.aluop1 = 1;                 push_step(c, 8, 0);
                c = '0; c.regwrite = 1; c.regdst = 1; c.done = 1;    push_step(c, 9, 1);
            end
            6'd2: begin
                c = '0; c.pcwrite = 1; c.pcsource = 2'b10; c.done = 1;
                push_step(c, 13, 1);
            end
            6'd4, 6'd6: begin
                c = '0; c.alusrca = 1; c.aluop2 = 1; c.pcwritecond = 1;
                c.pcsource = 2'b01; c.brtype = (o == 6'd6); c.done = 1;
                push_step(c, (o == 6'd6) ? 12 : 11, 1);
            end
            6'd8, 6'd9: begin
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.aluop2 = (o == 6'd9);
                push_step(c, (o == 6'd9) ? 7 : 6, 0);
                c = '0; c.regwrite = 1; c.done = 1;                  push_step(c, 10, 1);
            end
            6'd35, 6'd43: begin
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10;            push_step(c, 2, 0);
                if (o == 6'd35) begin
                    c = '0; c.memread = 1; c.iord = 1;               push_step(c, 3, 0);
                    c = '0; c.regwrite = 1; c.memtoreg = 1; c.done = 1;
                    push_step(c, 4, 1);
                end else begin
                    c = '0; c.memwrite = 1; c.iord = 1; c.done = 1;  push_step(c, 5, 1);
                end
            end
            default: ;
        endcase
        t.ill = !is_legal(o);
        t.lat = steps_n;
        t.op  = o;
        txn_q.push_back(t);
        repeat (steps_n) tick();
    endtask

    // lw interrupted by reset during its memory-read cycle.
    task automatic issue_lw_abort();
        ctl_t c;
        steps_n = 0;
        bus.op  = 6'd35;
        push_fetch_decode(6'd35);
        c = '0; c.alusrca = 1; c.alusrcb = 2'b10;
        push_step(c, 2, 0);
        repeat (3) tick();
        reset = 1'b1;
        push_reset_step();
        tick();
        reset     = 1'b0;
        model_cnt = '0;
    endtask

    always @(negedge clk) begin
        step_t e;
        ctl_t  a;
        txn_t  t;
        if (mon_en) begin
            a = {bus.pcwrite, bus.pcwritecond, bus.brtype, bus.iord, bus.memread,
                 bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite,
                 bus.alusrca, bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop2,
                 bus.done, bus.illegal};
            if (reset) cyc = 0;
            else cyc++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL no_expectation: ctl=%h state=%0d at %0t", a, bus.state, $time);
            end else begin
                e = exp_q.pop_front();
                if (a !== e.c) begin
                    errors++;
                    $display("FAIL ctl_word: got %h want %h (state=%0d) at %0t",
                             a, e.c, bus.state, $time);
                end
                if (e.chk) begin
                    checks++;
                    if (bus.state !== e.st) begin
                        errors++;
                        $display("FAIL state: got %0d want %0d at %0t", bus.state, e.st, $time);
                    end
                    checks++;
                    if (bus.instr_count !== e.cnt) begin
                        errors++;
                        $display("FAIL instr_count: got %0d want %0d at %0t",
                                 bus.instr_count, e.cnt, $time);
                    end
                end
            end
            if (a.done || a.illegal) begin
                checks++;
                if (txn_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b illegal=%0b at %0t",
                             a.done, a.illegal, $time);
                end else begin
                    t = txn_q.pop_front();
                    if (a.illegal !== t.ill || a.done !== !t.ill || cyc != t.lat) begin
                        errors++;
                        $display("FAIL txn op=%0d: got illegal=%0b latency=%0d want illegal=%0b latency=%0d",
                                 t.op, a.illegal, cyc, t.ill, t.lat);
                    end
                    $display("txn op=%0d latency=%0d illegal=%0b count=%0d",
                             t.op, cyc, a.illegal, bus.instr_count);
                end
                cyc = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] legal_ops [8];
        logic [5:0] o;
        int n;
        legal_ops = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd9, 6'd35, 6'd43};
        bus.op = 6'd35;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (3) push_reset_step();
        repeat (3) tick();
        reset     = 1'b0;
        model_cnt = '0;

        // Directed sequence from the test plan.
        issue(6'd35);
        issue(6'd0);
        issue(6'd9);
        issue(6'd8);
        issue(6'd6);
        issue(6'd4);
        issue(6'd63);
        issue(6'd43);
        issue(6'd2);

        // Randomized mix, biased toward legal opcodes.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 4) != 0) o = legal_ops[$urandom_range(0, 7)];
            else o = 6'($urandom_range(0, 63));
            issue(o);
        end

        // Drive the counter through all-ones and back to zero with jumps.
        n = (1 << CNT_W) - int'(model_cnt);
        for (int i = 0; i < n; i++) issue(6'd2);
        issue(6'd2);

        issue_lw_abort();
        issue(6'd8);
        issue(6'd63);

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0 || txn_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d steps %0d txns pending want 0 0",
                     exp_q.size(), txn_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle custom MIPS datapath. It sequences fetch, decode, execute, memory and writeback per instruction from the 6-bit opcode. It drives every datapath strobe, including the aluop1/aluop2 mode pair consumed by the ALU control decoder. It also counts retired instructions and flags illegal opcodes.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  opcode from instruction register, stable from DECODE until FETCH
pcwrite  out  1  unconditional PC load
pcwritecond  out  1  PC load if branch condition true
brtype  out  1  branch condition select: 0 = ALU zero (beq), 1 = ALU result sign (blt)
iord  out  1  memory address: 0 = PC, 1 = ALUOut
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
memtoreg  out  1  register write data: 0 = ALUOut, 1 = MDR
regdst  out  1  destination: 0 = rt, 1 = rd
regwrite  out  1  register file write strobe
alusrca  out  1  ALU A: 0 = PC, 1 = A register
alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
pcsource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
aluop1  out  1  R-type mode to ALU control
aluop2  out  1  subtract mode to ALU control
done  out  1  one-cycle pulse in the last state of each legal instruction
illegal  out  1  one-cycle pulse in DECODE on an unknown opcode
state  out  4  current state encoding, for debug
instr_count  out  CNT_W  retired legal instructions

Behaviour:
- Opcodes: R-type 0, j 2, beq 4, blt 6, addi 8, subi 9, lw 35, sw 43. All other opcodes are illegal.
- Moore FSM. All outputs decode from the state register only. Signals not listed for a state are 0.
- State encodings 0..13 are listed below. Unused encodings go to FETCH on the next cycle with all outputs 0.
- 0 FETCH: memread, irwrite, pcwrite, alusrcb=01, aluop=00. Always goes to DECODE.
- 1 DECODE: alusrcb=11, aluop=00 (branch target into ALUOut).
  - R-type -> 8; j -> 13; beq -> 11; blt -> 12; addi -> 6; subi -> 7; lw/sw -> 2.
  - Illegal opcode -> FETCH with illegal=1.
- 2 MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> 3; sw -> 5.
- 3 MEMRD: memread, iord. Goes to 4.
- 4 MEMWB: regwrite, memtoreg, regdst=0, done. Goes to FETCH.
- 5 MEMWR: memwrite, iord, done. Goes to FETCH.
- 6 ADDI_EX: alusrca=1, alusrcb=10, aluop=00. Goes to 10.
- 7 SUBI_EX: alusrca=1, alusrcb=10, aluop=01. Goes to 10.
- 8 RTYPE_EX: alusrca=1, alusrcb=00, aluop=10. Goes to 9.
- 9 RTYPE_WB: regwrite, regdst=1, memtoreg=0, done. Goes to FETCH.
- 10 IMM_WB: regwrite, regdst=0, memtoreg=0, done. Goes to FETCH.
- 11 BEQ: alusrca=1, alusrcb=00, aluop=01, pcwritecond, pcsource=01, brtype=0, done. Goes to FETCH.
- 12 BLT: same as BEQ except brtype=1.
- 13 JUMP: pcwrite, pcsource=10, done. Goes to FETCH.
- aluop=11 is never driven.
- Latency in cycles, FETCH through the done state:
  - lw 5
  - sw, R-type, addi, subi 4
  - beq, blt, j 3
  - illegal 2, no done pulse
- instr_count:
  - Increments by 1 on every clock edge where done=1.
  - Wraps from all-ones to 0.
  - Does not count illegal opcodes.
- Reset:
  - On the clk edge with reset=1: state <= FETCH and instr_count <= 0. The same applies mid-instruction; any partial instruction is abandoned.
  - While reset=1, pcwrite, pcwritecond, memwrite, regwrite, irwrite, done and illegal are forced to 0 combinationally.
  - All other outputs during reset take their FETCH values: memread=1, alusrcb=01, remaining fields 0.
- The first FETCH after reset deasserts performs a normal fetch.

Test Plan:
- Reset held 3 cycles, then released with op=35 -> state sequence 0,1,2,3,4,0. memread in states 0 and 3 with iord=1 in 3; regwrite=1 and memtoreg=1 in state 4; instr_count=1.
- op=0 (R-type) -> aluop1=1, aluop2=0 only in RTYPE_EX. regwrite=1 and regdst=1 one cycle later. Total 4 cycles.
- op=9 (subi), then op=8 (addi) -> SUBI_EX drives aluop=01, ADDI_EX drives aluop=00. Both pass through IMM_WB with regdst=0. instr_count +2.
- op=6 (blt), then op=4 (beq) -> pcwritecond=1, pcsource=01, aluop=01 in both. brtype=1 then 0. Each takes 3 cycles.
- op=63 -> illegal=1 for exactly one cycle in DECODE, next state FETCH, instr_count unchanged, no write strobes.
- Preload instr_count to 0xFFFF via 65535 j instructions, then one more j -> count=0x0000.
- reset=1 asserted during MEMRD of lw -> regwrite never asserts, state=0 next cycle, instr_count=0.
